// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SD card CMD-line engine.
package sdcard_pkg;

    typedef enum logic [1:0] {
        RESP_NONE     = 2'b00,
        RESP_48       = 2'b01,
        RESP_136      = 2'b10,
        RESP_48_NOCRC = 2'b11
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_RECOVER
    } cmd_state_t;

    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam int         CMD_FRAME_LEN  = 48;
    localparam int         R2_FRAME_LEN   = 136;
    localparam logic [5:0] R2_CHECK_FIELD = 6'h3F;
    localparam int         TX_CRC_START   = 40;

endpackage

// File: rtl/sdcard_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per enable; shared by TX and RX.
module sdcard_crc7
    import sdcard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        // NOTE: defaults first so every path assigns every variable; otherwise a latch is inferred.
        crc_d = crc_q;
        fb    = din_i ^ crc_q[6];
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) for all state so every flop samples pre-edge values.
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdcard_cmd_engine.sv
// CMD-line engine: serialises a 48-bit command on SD clock falls, then samples and checks
// the card response on SD clock rises. SD clock is edge-detected in the PCLK domain.
module sdcard_cmd_engine
    import sdcard_pkg::*;
#(
    parameter int NCR_MAX    = 64,
    parameter int NCC_CYCLES = 8
) (
    input  logic         PCLK_i,
    input  logic         PRESETn_i,
    input  logic         sd_clk_i,
    input  logic         cmd_start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         abort_i,
    output logic         cmd_busy_o,
    output logic         cmd_done_o,
    output logic [127:0] resp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         index_err_o,
    output logic         end_err_o,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe_o,
    input  logic         sd_cmd_i
);

    cmd_state_t   state_q, state_d;
    resp_type_t   type_q, type_d;
    logic         sd_clk_q;
    logic [5:0]   idx_q, idx_d;
    logic [47:0]  tx_sr_q, tx_sr_d;
    logic [132:0] rx_sr_q, rx_sr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic [127:0] resp_q, resp_d;
    logic         to_err_q, to_err_d, crc_err_q, crc_err_d;
    logic         idx_err_q, idx_err_d, end_err_q, end_err_d;
    logic         cmd_q, cmd_d, oe_q, oe_d;

    logic         rise, fall;
    logic [7:0]   rx_len, rx_idx;
    logic [133:0] rx_full;
    logic         crc_clr, crc_en, crc_din;
    logic [6:0]   crc_val;

    assign rise    = sd_clk_i & ~sd_clk_q;
    assign fall    = ~sd_clk_i & sd_clk_q;
    assign rx_len  = (type_q == RESP_136) ? 8'(R2_FRAME_LEN) : 8'(CMD_FRAME_LEN);
    // Position (from the frame LSB) of the bit arriving on this rise.
    assign rx_idx  = rx_len - 8'd1 - cnt_q;
    assign rx_full = {rx_sr_q, sd_cmd_i};

    sdcard_crc7 u_crc7 (
        .clk   (PCLK_i),
        .rst_n (PRESETn_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (crc_din),
        .crc_o (crc_val)
    );

    always_comb begin
        state_d = state_q;  type_d = type_q;  idx_d = idx_q;
        tx_sr_d = tx_sr_q;  rx_sr_d = rx_sr_q; cnt_d = cnt_q;
        busy_d  = busy_q;   done_d  = 1'b0;    resp_d = resp_q;
        to_err_d = to_err_q; crc_err_d = crc_err_q;
        idx_err_d = idx_err_q; end_err_d = end_err_q;
        cmd_d = cmd_q; oe_d = oe_q;
        crc_clr = 1'b0; crc_en = 1'b0; crc_din = 1'b0;

        if (state_q != ST_IDLE && abort_i) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cmd_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    crc_clr = 1'b1;
                    if (cmd_start_i) begin
                        idx_d     = cmd_index_i;
                        type_d    = resp_type_t'(resp_type_i);
                        tx_sr_d   = {1'b0, 1'b1, cmd_index_i, cmd_arg_i, 7'h00, 1'b1};
                        resp_d    = '0;
                        to_err_d  = 1'b0; crc_err_d = 1'b0;
                        idx_err_d = 1'b0; end_err_d = 1'b0;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fall) begin
                        if (cnt_q < 8'(CMD_FRAME_LEN)) begin
                            oe_d    = 1'b1;
                            cmd_d   = (cnt_q >= 8'(TX_CRC_START) && cnt_q < 8'd47)
                                      ? crc_val[3'(8'd46 - cnt_q)] : tx_sr_q[47];
                            crc_en  = (cnt_q < 8'(TX_CRC_START));
                            crc_din = tx_sr_q[47];
                            tx_sr_d = {tx_sr_q[46:0], 1'b0};
                            cnt_d   = cnt_q + 8'd1;
                        end else begin
                            oe_d    = 1'b0;
                            cmd_d   = 1'b1;
                            cnt_d   = '0;
                            crc_clr = 1'b1;
                            state_d = (type_q == RESP_NONE) ? ST_RECOVER : ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (rise) begin
                        if (!sd_cmd_i) begin
                            rx_sr_d = '0;
                            cnt_d   = 8'd1;
                            state_d = ST_RECV;
                        end else if (int'(cnt_q) == NCR_MAX - 1) begin
                            to_err_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_RECOVER;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (rise) begin
                        rx_sr_d = rx_full[132:0];
                        cnt_d   = cnt_q + 8'd1;
                        crc_en  = (rx_idx >= 8'd8) && (rx_idx <= 8'd127);
                        crc_din = sd_cmd_i;
                        if (rx_idx == 8'd0) begin
                            end_err_d = ~rx_full[0];
                            case (type_q)
                                RESP_136: begin
                                    idx_err_d = (rx_full[133:128] != R2_CHECK_FIELD);
                                    crc_err_d = (rx_full[7:1] != crc_val);
                                    resp_d    = {8'h00, rx_full[127:8]};
                                end
                                RESP_48_NOCRC: begin
                                    idx_err_d = rx_full[46];
                                    resp_d    = {96'h0, rx_full[39:8]};
                                end
                                default: begin
                                    idx_err_d = rx_full[46] | (rx_full[45:40] != idx_q);
                                    crc_err_d = (rx_full[7:1] != crc_val);
                                    resp_d    = {96'h0, rx_full[39:8]};
                                end
                            endcase
                            cnt_d   = '0;
                            state_d = ST_RECOVER;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (rise) begin
                        if (int'(cnt_q) == NCC_CYCLES - 1) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q  <= ST_IDLE;   type_q    <= RESP_NONE; sd_clk_q  <= 1'b0;
            idx_q    <= '0;        tx_sr_q   <= '0;        rx_sr_q   <= '0;
            cnt_q    <= '0;        busy_q    <= 1'b0;      done_q    <= 1'b0;
            resp_q   <= '0;        to_err_q  <= 1'b0;      crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;     end_err_q <= 1'b0;
            cmd_q    <= 1'b1;      oe_q      <= 1'b0;
        end else begin
            state_q  <= state_d;   type_q    <= type_d;    sd_clk_q  <= sd_clk_i;
            idx_q    <= idx_d;     tx_sr_q   <= tx_sr_d;   rx_sr_q   <= rx_sr_d;
            cnt_q    <= cnt_d;     busy_q    <= busy_d;    done_q    <= done_d;
            resp_q   <= resp_d;    to_err_q  <= to_err_d;  crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d; end_err_q <= end_err_d;
            cmd_q    <= cmd_d;     oe_q      <= oe_d;
        end
    end

    assign cmd_busy_o    = busy_q;
    assign cmd_done_o    = done_q;
    assign resp_o        = resp_q;
    assign timeout_err_o = to_err_q;
    assign crc_err_o     = crc_err_q;
    assign index_err_o   = idx_err_q;
    assign end_err_o     = end_err_q;
    assign sd_cmd_o      = cmd_q;
    assign sd_cmd_oe_o   = oe_q;

endmodule

// File: tb/tb_sdcard_cmd_engine.sv
// Bench for sdcard_cmd_engine: a card model on the SD clock, a polynomial-division CRC
// reference, and directed plus randomised command/response scenarios.
module tb_sdcard_cmd_engine;
    import sdcard_pkg::*;

    localparam int NCR = 64;
    localparam int NCC = 8;

    logic         pclk = 1'b0, rst_n = 1'b0, sd_clk = 1'b0;
    logic         cmd_start = 1'b0, abort = 1'b0, sd_cmd_in = 1'b1;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         busy, done, te, ce, ie, ee, cmd_out, cmd_oe;
    logic [127:0] resp;

    int n_checks = 0, n_pass = 0;
    int half_div = 1, phase = 0, rel_rises = 0, card_wait = 0;
    bit card_arm = 1'b0;
    logic tx_q[$];
    logic resp_bits[$];

    sdcard_cmd_engine #(.NCR_MAX(NCR), .NCC_CYCLES(NCC)) dut (
        .PCLK_i(pclk), .PRESETn_i(rst_n), .sd_clk_i(sd_clk),
        .cmd_start_i(cmd_start), .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg),
        .resp_type_i(resp_type), .abort_i(abort),
        .cmd_busy_o(busy), .cmd_done_o(done), .resp_o(resp),
        .timeout_err_o(te), .crc_err_o(ce), .index_err_o(ie), .end_err_o(ee),
        .sd_cmd_o(cmd_out), .sd_cmd_oe_o(cmd_oe), .sd_cmd_i(sd_cmd_in)
    );

    initial forever #5 pclk = ~pclk;

    // SD clock generator plus card: host bits sampled on rises, reply bits driven on falls.
    initial forever begin
        @(negedge pclk);
        phase++;
        if (phase >= half_div) begin
            phase = 0;
            if (!sd_clk) begin
                if (cmd_oe) tx_q.push_back(cmd_out);
                else if (tx_q.size() >= 48) rel_rises++;
                sd_clk = 1'b1;
            end else begin
                sd_clk = 1'b0;
                if (card_arm && tx_q.size() >= 48 && !cmd_oe) begin
                    if (card_wait > 0) card_wait--;
                    else if (resp_bits.size() > 0) sd_cmd_in = resp_bits.pop_front();
                    else begin sd_cmd_in = 1'b1; card_arm = 1'b0; end
                end
            end
        end
    end

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int nbits);
        logic [126:0] r;
        r = {msg, 7'b0};
        for (int i = nbits + 6; i >= 7; i--)
            if (r[i]) r = r ^ (127'(8'h89) << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        b = {2'b01, idx, arg};
        return {b, crc7_ref(120'(b), 40), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_flags(input string tag, input logic [127:0] er,
                               input bit ete, input bit ece, input bit eie, input bit eee);
        check({tag, "_resp"}, resp, er);
        check({tag, "_timeout"}, 128'(te), 128'(ete));
        check({tag, "_crc"}, 128'(ce), 128'(ece));
        check({tag, "_index"}, 128'(ie), 128'(eie));
        check({tag, "_end"}, 128'(ee), 128'(eee));
    endtask

    task automatic check_tx(input string tag, input logic [47:0] exp);
        logic [47:0] v = '0;
        for (int i = 0; i < tx_q.size() && i < 48; i++) v = {v[46:0], tx_q[i]};
        check({tag, "_txlen"}, 128'(tx_q.size()), 128'(48));
        check({tag, "_txframe"}, 128'(v), 128'(exp));
    endtask

    task automatic load_resp(input logic [135:0] v, input int len);
        resp_bits.delete();
        for (int i = len - 1; i >= 0; i--) resp_bits.push_back(v[i]);
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] t,
                             input int delay, input bit arm);
        half_div  = int'($urandom_range(1, 3));
        tx_q.delete();
        rel_rises = 0;
        card_wait = delay;
        card_arm  = arm;
        @(negedge pclk);
        cmd_index = idx; cmd_arg = arg; resp_type = t; cmd_start = 1'b1;
        @(negedge pclk);
        cmd_start = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic finish_cmd(input string tag, output int rises);
        bit seen = 1'b0;
        rises = -1;
        for (int c = 0; c < 6000 && !seen; c++) begin
            @(negedge pclk);
            if (done) begin seen = 1'b1; rises = rel_rises; end
        end
        check({tag, "_done_seen"}, 128'(seen), 128'(1));
        check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
        @(negedge pclk);
        check({tag, "_done_one_cycle"}, 128'(done), 128'(0));
    endtask

    // Reference reply and expected outcome for response type t with an optional fault:
    // 1 = bad CRC, 2 = bad index/check field/transmission bit, 3 = end bit 0.
    task automatic build_reply(input logic [1:0] t, input logic [5:0] idx, input int fault,
                               output logic [135:0] fr, output int len, output logic [127:0] er,
                               output bit eie, output bit ece, output bit eee);
        logic [39:0]  body;
        logic [127:0] rnd;
        logic [119:0] pl;
        logic [6:0]   crc;
        logic         endb;
        endb = (fault == 3) ? 1'b0 : 1'b1;
        eee  = (fault == 3);
        eie  = (fault == 2);
        ece  = 1'b0;
        if (t == RESP_136) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            pl  = rnd[119:0];
            crc = crc7_ref(pl, 120) ^ ((fault == 1) ? 7'h01 : 7'h00);
            ece = (fault == 1);
            fr  = {2'b00, (fault == 2) ? 6'h3E : 6'h3F, pl, crc, endb};
            len = 136;
            er  = {8'h00, pl};
        end else begin
            body = {2'b00, (t == RESP_48 && fault == 2) ? idx ^ 6'h01 : idx, $urandom()};
            if (t == RESP_48_NOCRC && fault == 2) body[38] = 1'b1;
            if (t == RESP_48) begin
                crc = crc7_ref(120'(body), 40) ^ ((fault == 1) ? 7'h01 : 7'h00);
                ece = (fault == 1);
            end else begin
                crc = 7'($urandom());
            end
            fr  = 136'({body, crc, endb});
            len = 48;
            er  = {96'h0, body[31:0]};
        end
    endtask

    initial begin
        logic [135:0] fr;
        logic [127:0] er;
        logic [31:0]  rarg;
        logic [5:0]   ridx;
        logic [1:0]   rt;
        int           len, rr, dn;
        bit           eie, ece, eee, hit;

        repeat (3) @(negedge pclk);
        check("rst_cmd_o", 128'(cmd_out), 128'(1));
        check("rst_oe", 128'(cmd_oe), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check_flags("rst", '0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge pclk);

        // CMD0, no response
        start_cmd(6'd0, 32'd0, RESP_NONE, 0, 1'b0);
        finish_cmd("cmd0", rr);
        check_tx("cmd0", 48'h400000000095);
        check("cmd0_ncc_rises", 128'(rr), 128'(NCC));
        check_flags("cmd0", '0, 0, 0, 0, 0);

        // CMD8 with the canonical R7 reply
        load_resp(136'(48'h08000001AA13), 48);
        start_cmd(6'd8, 32'h1AA, RESP_48, 10, 1'b1);
        finish_cmd("cmd8", rr);
        check_tx("cmd8", cmd_frame(6'd8, 32'h1AA));
        check_flags("cmd8", 128'h1AA, 0, 0, 0, 0);

        // CMD17: corrupted CRC, then wrong index
        build_reply(RESP_48, 6'd17, 1, fr, len, er, eie, ece, eee);
        load_resp(fr, len);
        start_cmd(6'd17, 32'd0, RESP_48, 4, 1'b1);
        finish_cmd("cmd17_crc", rr);
        check_flags("cmd17_crc", er, 0, 1, 0, 0);
        build_reply(RESP_48, 6'd17, 2, fr, len, er, eie, ece, eee);
        load_resp(fr, len);
        start_cmd(6'd17, 32'd0, RESP_48, 4, 1'b1);
        finish_cmd("cmd17_idx", rr);
        check_flags("cmd17_idx", er, 0, 0, 1, 0);

        // CMD55 with no card reply
        start_cmd(6'd55, 32'h0, RESP_48, 0, 1'b0);
        finish_cmd("cmd55", rr);
        check("cmd55_ncr_ncc_rises", 128'(rr), 128'(NCR + NCC));
        check_flags("cmd55", '0, 1, 0, 0, 0);

        // CMD2 with a valid 136-bit reply
        build_reply(RESP_136, 6'd2, 0, fr, len, er, eie, ece, eee);
        load_resp(fr, len);
        start_cmd(6'd2, 32'h0, RESP_136, 6, 1'b1);
        finish_cmd("cmd2", rr);
        check_flags("cmd2", er, 0, 0, 0, 0);

        // Randomised commands against the reference reply model
        for (int n = 0; n < 8; n++) begin
            ridx = 6'($urandom());
            rarg = $urandom();
            rt   = 2'($urandom());
            build_reply(rt, ridx, int'($urandom_range(0, 3)), fr, len, er, eie, ece, eee);
            if (rt == RESP_NONE) begin
                er = '0; eie = 0; ece = 0; eee = 0;
            end
            load_resp(fr, len);
            start_cmd(ridx, rarg, rt, int'($urandom_range(1, 20)), rt != RESP_NONE);
            finish_cmd($sformatf("rnd%0d", n), rr);
            check_tx($sformatf("rnd%0d", n), cmd_frame(ridx, rarg));
            check_flags($sformatf("rnd%0d", n), er, 0, ece, eie, eee);
        end

        // Abort in the middle of an R2 reception
        build_reply(RESP_136, 6'd2, 0, fr, len, er, eie, ece, eee);
        load_resp(fr, len);
        start_cmd(6'd2, 32'h0, RESP_136, 5, 1'b1);
        hit = 1'b0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            @(negedge pclk);
            hit = (resp_bits.size() <= 100);
        end
        check("abort_reached_recv", 128'(hit), 128'(1));
        abort = 1'b1;
        @(negedge pclk);
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_oe", 128'(cmd_oe), 128'(0));
        check("abort_cmd_o", 128'(cmd_out), 128'(1));
        dn = 0;
        for (int c = 0; c < 2000; c++) begin
            if (done) dn++;
            @(negedge pclk);
        end
        check("abort_no_done", 128'(dn), 128'(0));
        check_flags("abort", '0, 0, 0, 0, 0);

        // Start request during SEND must not disturb the frame
        rarg = $urandom();
        start_cmd(6'd12, rarg, RESP_NONE, 0, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            @(negedge pclk);
            hit = (tx_q.size() >= 10);
        end
        check("send_reached", 128'(hit), 128'(1));
        cmd_index = 6'd40; cmd_arg = ~rarg; resp_type = RESP_48; cmd_start = 1'b1;
        @(negedge pclk);
        cmd_start = 1'b0;
        finish_cmd("busy_start", rr);
        check_tx("busy_start", cmd_frame(6'd12, rarg));
        check("busy_start_ncc_rises", 128'(rr), 128'(NCC));

        // Reset in the middle of SEND releases CMD at once
        start_cmd(6'd17, $urandom(), RESP_48, 0, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            @(negedge pclk);
            hit = (tx_q.size() >= 20) && cmd_oe;
        end
        check("rst_send_reached", 128'(hit), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_oe", 128'(cmd_oe), 128'(0));
        check("rst_mid_cmd_o", 128'(cmd_out), 128'(1));
        check("rst_mid_busy", 128'(busy), 128'(0));
        @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
